// File: rtl/wordle_scorer.sv
// Scores one five-letter guess against the latched answer (green pass, then yellow pass)
// and writes the colour codes plus the ready/win word through a shared regfile port.
module wordle_scorer #(
    parameter int unsigned COLOR_BASE = 17,
    parameter int unsigned READY_REG  = 1,
    parameter int unsigned LETTER_W   = 5
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    input  logic [31:0] data_corr0,
    input  logic [31:0] data_corr1,
    input  logic [31:0] data_corr2,
    input  logic [31:0] data_corr3,
    input  logic [31:0] data_corr4,
    input  logic [31:0] data_guess0,
    input  logic [31:0] data_guess1,
    input  logic [31:0] data_guess2,
    input  logic [31:0] data_guess3,
    input  logic [31:0] data_guess4,
    output logic        wr_req,
    input  logic        wr_gnt,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        busy,
    output logic        done,
    output logic        win
);

    localparam int unsigned NPOS   = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned COL_W  = 2;
    localparam logic [COL_W-1:0] COL_GREEN  = 2'd2;
    localparam logic [COL_W-1:0] COL_YELLOW = 2'd1;
    localparam logic [IDX_W-1:0] IDX_LAST   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_GREEN, S_YELLOW, S_WRITE, S_FLAG, S_DONE
    } state_t;

    state_t               state_q, state_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [LETTER_W-1:0]  corr_q  [NPOS];
    logic [LETTER_W-1:0]  corr_nxt[NPOS];
    logic [LETTER_W-1:0]  guess_q  [NPOS];
    logic [LETTER_W-1:0]  guess_nxt[NPOS];
    logic [LETTER_W-1:0]  corr_in [NPOS];
    logic [LETTER_W-1:0]  guess_in[NPOS];
    logic [COL_W-1:0]     col_q  [NPOS];
    logic [COL_W-1:0]     col_nxt[NPOS];
    logic [NPOS-1:0]      used_q, used_nxt;

    logic                 wr_req_nxt, busy_nxt, done_nxt, win_nxt;
    logic [REG_W-1:0]     reg_nxt;
    logic [DATA_W-1:0]    data_nxt;
    logic                 all_green;
    logic                 found;
    logic [IDX_W-1:0]     found_j;
    logic                 unused_hi;

    assign corr_in[0]  = data_corr0[LETTER_W-1:0];
    assign corr_in[1]  = data_corr1[LETTER_W-1:0];
    assign corr_in[2]  = data_corr2[LETTER_W-1:0];
    assign corr_in[3]  = data_corr3[LETTER_W-1:0];
    assign corr_in[4]  = data_corr4[LETTER_W-1:0];
    assign guess_in[0] = data_guess0[LETTER_W-1:0];
    assign guess_in[1] = data_guess1[LETTER_W-1:0];
    assign guess_in[2] = data_guess2[LETTER_W-1:0];
    assign guess_in[3] = data_guess3[LETTER_W-1:0];
    assign guess_in[4] = data_guess4[LETTER_W-1:0];

    assign unused_hi = ^{data_corr0[31:LETTER_W], data_corr1[31:LETTER_W],
                         data_corr2[31:LETTER_W], data_corr3[31:LETTER_W],
                         data_corr4[31:LETTER_W], data_guess0[31:LETTER_W],
                         data_guess1[31:LETTER_W], data_guess2[31:LETTER_W],
                         data_guess3[31:LETTER_W], data_guess4[31:LETTER_W]};

    // Strobe must follow the grant in the same cycle, so it is not registered.
    assign ctrl_writeEnable = wr_req & wr_gnt;

    always_comb begin
        all_green = 1'b1;
        for (int i = 0; i < int'(NPOS); i++) begin
            if (col_q[i] != COL_GREEN) all_green = 1'b0;
        end
    end

    // Lowest unused answer position holding the current guess letter.
    always_comb begin
        found   = 1'b0;
        found_j = '0;
        for (int j = int'(NPOS) - 1; j >= 0; j--) begin
            if (corr_q[j] == guess_q[idx_q] && !used_q[j]) begin
                found   = 1'b1;
                found_j = IDX_W'(j);
            end
        end
    end

    // State register with registered outputs aligned to the state they belong to.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            used_q        <= '0;
            wr_req        <= 1'b0;
            ctrl_writeReg <= '0;
            data_writeReg <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            win           <= 1'b0;
            for (int i = 0; i < int'(NPOS); i++) begin
                corr_q[i]  <= '0;
                guess_q[i] <= '0;
                col_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_nxt;
            idx_q         <= idx_nxt;
            used_q        <= used_nxt;
            wr_req        <= wr_req_nxt;
            ctrl_writeReg <= reg_nxt;
            data_writeReg <= data_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            win           <= win_nxt;
            for (int i = 0; i < int'(NPOS); i++) begin
                corr_q[i]  <= corr_nxt[i];
                guess_q[i] <= guess_nxt[i];
                col_q[i]   <= col_nxt[i];
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        used_nxt  = used_q;
        corr_nxt  = corr_q;
        guess_nxt = guess_q;
        col_nxt   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    corr_nxt  = corr_in;
                    guess_nxt = guess_in;
                    used_nxt  = '0;
                    for (int i = 0; i < int'(NPOS); i++) col_nxt[i] = '0;
                    idx_nxt   = '0;
                    state_nxt = S_GREEN;
                end
            end
            S_GREEN: begin
                if (guess_q[idx_q] == corr_q[idx_q] && guess_q[idx_q] != '0) begin
                    col_nxt[idx_q]  = COL_GREEN;
                    used_nxt[idx_q] = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_nxt   = '0;
                    state_nxt = S_YELLOW;
                end else begin
                    idx_nxt = idx_q + 3'd1;
                end
            end
            S_YELLOW: begin
                if (col_q[idx_q] != COL_GREEN && guess_q[idx_q] != '0 && found) begin
                    col_nxt[idx_q]    = COL_YELLOW;
                    used_nxt[found_j] = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_nxt   = '0;
                    state_nxt = S_WRITE;
                end else begin
                    idx_nxt = idx_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (wr_gnt) begin
                    if (idx_q == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = S_FLAG;
                    end else begin
                        idx_nxt = idx_q + 3'd1;
                    end
                end
            end
            S_FLAG: begin
                if (wr_gnt) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered above.
    always_comb begin
        wr_req_nxt = 1'b0;
        reg_nxt    = '0;
        data_nxt   = '0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        win_nxt    = win;
        case (state_nxt)
            S_GREEN, S_YELLOW: busy_nxt = 1'b1;
            S_WRITE: begin
                busy_nxt   = 1'b1;
                wr_req_nxt = 1'b1;
                reg_nxt    = REG_W'(COLOR_BASE) + REG_W'(idx_nxt);
                data_nxt   = DATA_W'(col_nxt[idx_nxt]);
            end
            S_FLAG: begin
                busy_nxt   = 1'b1;
                wr_req_nxt = 1'b1;
                reg_nxt    = REG_W'(READY_REG);
                data_nxt   = DATA_W'({all_green, 1'b1});
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
        if (state_q == S_IDLE && start) win_nxt = 1'b0;
        if (state_q == S_FLAG && wr_gnt) win_nxt = all_green;
    end

endmodule

// File: tb/tb_wordle_scorer.sv
// Randomised and directed bench for wordle_scorer against a letter-count Wordle model.
module tb_wordle_scorer;

    typedef logic [4:0][4:0] word_t;
    typedef logic [4:0][1:0] cols_t;
    typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data_corr0 = '0, data_corr1 = '0, data_corr2 = '0, data_corr3 = '0, data_corr4 = '0;
    logic [31:0] data_guess0 = '0, data_guess1 = '0, data_guess2 = '0, data_guess3 = '0, data_guess4 = '0;
    logic        wr_req, wr_gnt = 1'b0, ctrl_writeEnable, busy, done, win;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int total = 0, bad = 0;
    int gnt_mode = 0, hold_left = 0, stalls = 0, dones = 0, writes = 0;
    wr_t exp_q[$];
    logic prev_stall = 1'b0;
    logic [4:0] prev_reg;
    logic [31:0] prev_data;

    wordle_scorer dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
        .data_corr0(data_corr0), .data_corr1(data_corr1), .data_corr2(data_corr2),
        .data_corr3(data_corr3), .data_corr4(data_corr4),
        .data_guess0(data_guess0), .data_guess1(data_guess1), .data_guess2(data_guess2),
        .data_guess3(data_guess3), .data_guess4(data_guess4),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .busy(busy), .done(done), .win(win)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic word_t w5(input string s);
        word_t w;
        for (int i = 0; i < 5; i++) w[i] = 5'(s[i] - 8'd64);
        return w;
    endfunction

    // Standard Wordle scoring by remaining letter counts.
    function automatic cols_t model(input word_t c, input word_t g);
        int cnt[32];
        cols_t r;
        r = '0;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            if (g[i] != 0 && g[i] == c[i]) r[i] = 2'd2;
            else if (c[i] != 0) cnt[c[i]]++;
        end
        for (int i = 0; i < 5; i++) begin
            if (r[i] != 2'd2 && g[i] != 0 && cnt[g[i]] > 0) begin
                r[i] = 2'd1;
                cnt[g[i]]--;
            end
        end
        return r;
    endfunction

    task automatic drive_words(input word_t c, input word_t g);
        data_corr0 = {27'($urandom), c[0]}; data_guess0 = {27'($urandom), g[0]};
        data_corr1 = {27'($urandom), c[1]}; data_guess1 = {27'($urandom), g[1]};
        data_corr2 = {27'($urandom), c[2]}; data_guess2 = {27'($urandom), g[2]};
        data_corr3 = {27'($urandom), c[3]}; data_guess3 = {27'($urandom), g[3]};
        data_corr4 = {27'($urandom), c[4]}; data_guess4 = {27'($urandom), g[4]};
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < 5; i++) w[i] = 5'($urandom_range(0, 5));
        return w;
    endfunction

    task automatic push_expect(input cols_t e);
        wr_t x;
        for (int i = 0; i < 5; i++) begin
            x.r = 5'(17 + i);
            x.d = 32'(e[i]);
            exp_q.push_back(x);
        end
        x.r = 5'd1;
        x.d = (e == {5{2'd2}}) ? 32'd3 : 32'd1;
        exp_q.push_back(x);
    endtask

    // Grant driver: tied high, random, or held low three cycles on the r19 request.
    always @(posedge clock) begin
        #1;
        case (gnt_mode)
            0: wr_gnt = 1'b1;
            1: wr_gnt = ($urandom % 3) != 0;
            default: begin
                if (wr_req && ctrl_writeReg == 5'd19 && hold_left > 0) begin
                    wr_gnt = 1'b0;
                    hold_left--;
                end else begin
                    wr_gnt = 1'b1;
                end
            end
        endcase
    end

    // Per-cycle compare: every write against the expected queue, strobe rule, stall hold.
    always @(negedge clock) begin
        if (!ctrl_reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("we_rule", 32'(ctrl_writeEnable), 32'(wr_req & wr_gnt));
            if (ctrl_writeEnable) begin
                writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_reg", 32'(ctrl_writeReg), 32'hFFFF_FFFF);
                end else begin
                    wr_t x;
                    x = exp_q.pop_front();
                    chk("write_reg", 32'(ctrl_writeReg), 32'(x.r));
                    chk("write_data", data_writeReg, x.d);
                end
            end
            if (prev_stall) begin
                chk("stall_req", 32'(wr_req), 32'd1);
                chk("stall_reg", 32'(ctrl_writeReg), 32'(prev_reg));
                chk("stall_data", data_writeReg, prev_data);
            end
            if (wr_req && !wr_gnt) stalls++;
            if (done) begin
                dones++;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            prev_stall = wr_req && !wr_gnt;
            prev_reg   = ctrl_writeReg;
            prev_data  = data_writeReg;
        end
    end

    task automatic run_job(input word_t c, input word_t g, input cols_t e, input int mode,
                           input bit chaos);
        int n, d0, exp_lat;
        logic ag;
        ag = (e == {5{2'd2}});
        push_expect(e);
        gnt_mode  = mode;
        hold_left = 3;
        @(posedge clock); #1;
        drive_words(c, g);
        start = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        stalls = 0;
        d0     = dones;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("win_cleared", 32'(win), 32'd0);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clock); #1;
            n++;
            if (chaos && n == 3) begin
                start = 1'b1;
                drive_words(rand_word(), rand_word());
            end
            if (chaos && n == 4) start = 1'b0;
        end
        chk("done_seen", 32'(done), 32'd1);
        exp_lat = 18 + stalls;
        chk("latency", 32'(n + 2), 32'(exp_lat));
        if (mode == 2) chk("stall_count", 32'(stalls), 32'd3);
        chk("win", 32'(win), 32'(ag));
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        repeat (chaos ? 25 : 3) @(posedge clock);
        #1;
        chk("one_done", 32'(dones - d0), 32'd1);
        chk("win_held", 32'(win), 32'(ag));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        word_t c, g;
        cols_t lit;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
        chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
        chk("rst_data", data_writeReg, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        ctrl_reset = 1'b1;

        lit = {2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
        chk("pin_abide_speed", 32'(model(w5("ABIDE"), w5("SPEED"))), 32'(lit));
        run_job(w5("ABIDE"), w5("SPEED"), lit, 0, 1'b0);

        lit = {2'd1, 2'd2, 2'd1, 2'd0, 2'd0};
        chk("pin_robot_floor", 32'(model(w5("ROBOT"), w5("FLOOR"))), 32'(lit));
        run_job(w5("ROBOT"), w5("FLOOR"), lit, 0, 1'b0);

        lit = {5{2'd2}};
        chk("pin_crane", 32'(model(w5("CRANE"), w5("CRANE"))), 32'(lit));
        run_job(w5("CRANE"), w5("CRANE"), lit, 0, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        chk("win_held_idle", 32'(win), 32'd1);

        run_job(w5("ABIDE"), w5("SPEED"), model(w5("ABIDE"), w5("SPEED")), 2, 1'b0);

        // Reset while scoring position 3 of the yellow pass.
        gnt_mode = 0;
        @(posedge clock); #1;
        drive_words(w5("CRANE"), w5("CRANE"));
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_req", 32'(wr_req), 32'd0);
        chk("abort_win", 32'(win), 32'd0);
        chk("abort_we", 32'(ctrl_writeEnable), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        writes = 0;
        repeat (25) @(posedge clock);
        #1;
        chk("no_write_after_abort", 32'(writes), 32'd0);
        run_job(w5("ROBOT"), w5("FLOOR"), model(w5("ROBOT"), w5("FLOOR")), 0, 1'b0);

        run_job(w5("ABIDE"), w5("SPEED"), model(w5("ABIDE"), w5("SPEED")), 1, 1'b1);

        for (int t = 0; t < 24; t++) begin
            c = rand_word();
            g = (t % 6 == 0) ? c : rand_word();
            run_job(c, g, model(c, g), (t % 3 == 0) ? 0 : 1, (t % 5 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
